stopwatch_ctrl: RTL

Control sequencer for the stopwatch datapath (100 Hz / second / minute counter chain). Turns two raw push-buttons into the chain's `start` run-enable and a one-cycle clear. It also captures lap times into a small buffer and selects what the 7-bit display fields show. It sits between the board buttons and the stopwatch counter chain, and feeds the display multiplexer.

---
 rtl/stopwatch_pkg.sv | 28 ++
 rtl/stopwatch_ctrl_btn_debounce.sv | 54 +++++
 rtl/stopwatch_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch control sequencer: FSM states, counter width and time record.
// Helpers classify each state by run-enable and by display source.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_LAP   = 2'd2,
        ST_PAUSE = 2'd3
    } sw_state_t;

    localparam int CNT_W = 7;

    typedef struct packed {
        logic [CNT_W-1:0] min;
        logic [CNT_W-1:0] sec;
        logic [CNT_W-1:0] hsec;
    } sw_time_t;

    function automatic logic is_counting(input sw_state_t s);
        return (s == ST_RUN) || (s == ST_LAP);
    endfunction

    function automatic logic shows_live(input sw_state_t s);
        return (s == ST_RUN) || (s == ST_PAUSE);
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stable-level debounce, rising-edge pulse.
// Latency: pulse 2 + DEBOUNCE_CYCLES + 1 cycles after a clean press; no backpressure.
// A level held through reset is ignored until the synchronized input has been seen low.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_pulse
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    r_sync;
    logic [1:0]    r_sync_vld;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_level_d;
    logic          r_armed;
    logic          r_pulse;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync     <= '0;
            r_sync_vld <= '0;
            r_cnt      <= '0;
            r_level    <= 1'b0;
            r_level_d  <= 1'b0;
            r_armed    <= 1'b0;
            r_pulse    <= 1'b0;
        end else begin
            r_sync     <= {r_sync[0], i_btn};
            r_sync_vld <= {r_sync_vld[0], 1'b1};
            // Any sample matching the accepted level restarts the stability count.
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == LAST) begin
                r_cnt   <= '0;
                r_level <= r_sync[1];
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_level_d <= r_level;
            if (r_sync_vld[1] && !r_sync[1]) begin
                r_armed <= 1'b1;
            end
            r_pulse <= r_armed && r_level && !r_level_d;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: debounced buttons drive run/lap/pause FSM, lap buffer and display mux.
// Latency: outputs register one cycle after a button pulse; lap_rd_* is a combinational read.
// No backpressure: pa beats a same-cycle pb, laps beyond LAP_DEPTH are dropped.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LAP_DEPTH       = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         btn_a,
    input  logic                         btn_b,
    input  logic [CNT_W-1:0]             hsec_in,
    input  logic [CNT_W-1:0]             sec_in,
    input  logic [CNT_W-1:0]             min_in,
    input  logic [$clog2(LAP_DEPTH)-1:0] lap_sel,
    output logic                         start,
    output logic                         clr,
    output logic [CNT_W-1:0]             disp_hsec,
    output logic [CNT_W-1:0]             disp_sec,
    output logic [CNT_W-1:0]             disp_min,
    output logic [CNT_W-1:0]             lap_rd_hsec,
    output logic [CNT_W-1:0]             lap_rd_sec,
    output logic [CNT_W-1:0]             lap_rd_min,
    output logic [$clog2(LAP_DEPTH):0]   lap_count,
    output logic                         lap_full,
    output logic [1:0]                   state
);
    localparam int SEL_W = $clog2(LAP_DEPTH);
    localparam int LCW   = SEL_W + 1;
    localparam logic [LCW-1:0] DEPTH = LCW'(LAP_DEPTH);

    logic       w_pa;
    logic       w_pb_raw;
    logic       w_pb;
    logic       w_capture;
    logic       w_clear;
    sw_state_t  r_state;
    sw_state_t  w_state_nxt;
    sw_time_t   w_live;
    sw_time_t   w_view_nxt;
    sw_time_t   w_rd;
    sw_time_t   r_view;
    sw_time_t   r_disp;
    sw_time_t   r_lap [LAP_DEPTH];
    logic [LCW-1:0]   r_lap_count;
    logic [LCW-1:0]   w_lap_count_nxt;
    logic [SEL_W-1:0] w_wr_idx;
    logic       r_start;
    logic       r_clr;
    logic       r_full;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .i_clk(clk), .i_rst_n(rst), .i_btn(btn_a), .o_pulse(w_pa)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .i_clk(clk), .i_rst_n(rst), .i_btn(btn_b), .o_pulse(w_pb_raw)
    );

    assign w_pb     = w_pb_raw & ~w_pa;
    assign w_live   = {min_in, sec_in, hsec_in};
    assign w_wr_idx = r_lap_count[SEL_W-1:0];

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pa)      w_state_nxt = ST_RUN;
                else if (w_pb) w_clear     = 1'b1;
            end
            ST_RUN: begin
                if (w_pa) begin
                    w_state_nxt = ST_PAUSE;
                end else if (w_pb) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_LAP;
                end
            end
            ST_LAP: begin
                if (w_pa)      w_state_nxt = ST_RUN;
                else if (w_pb) w_capture   = 1'b1;
            end
            ST_PAUSE: begin
                if (w_pa) begin
                    w_state_nxt = ST_RUN;
                end else if (w_pb) begin
                    w_clear     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_view_nxt      = r_view;
        w_lap_count_nxt = r_lap_count;
        if (w_clear) begin
            w_view_nxt      = '0;
            w_lap_count_nxt = '0;
        end else if (w_capture) begin
            w_view_nxt = w_live;
            if (!r_full) w_lap_count_nxt = r_lap_count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_start     <= 1'b0;
            r_clr       <= 1'b0;
            r_view      <= '0;
            r_disp      <= '0;
            r_lap_count <= '0;
            r_full      <= 1'b0;
            for (int i = 0; i < LAP_DEPTH; i++) r_lap[i] <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_start     <= is_counting(w_state_nxt);
            r_clr       <= w_clear;
            r_view      <= w_view_nxt;
            r_lap_count <= w_lap_count_nxt;
            r_full      <= (w_lap_count_nxt == DEPTH);
            r_disp      <= shows_live(w_state_nxt) ? w_live : w_view_nxt;
            if (w_capture && !r_full) r_lap[w_wr_idx] <= w_live;
        end
    end

    // Entries past lap_count may hold stale laps from before a clear; mask them.
    assign w_rd = ({1'b0, lap_sel} < r_lap_count) ? r_lap[lap_sel] : '0;

    assign state       = r_state;
    assign start       = r_start;
    assign clr         = r_clr;
    assign disp_min    = r_disp.min;
    assign disp_sec    = r_disp.sec;
    assign disp_hsec   = r_disp.hsec;
    assign lap_rd_min  = w_rd.min;
    assign lap_rd_sec  = w_rd.sec;
    assign lap_rd_hsec = w_rd.hsec;
    assign lap_count   = r_lap_count;
    assign lap_full    = r_full;

endmodule
